// File: rtl/fpu_addsub_pipe.sv
// Five-stage pipelined floating-point adder/subtractor (capture, align, add, normalize, round/pack).
// Denormals flush to zero; round-to-nearest-even; one global advance stalls all stages together.
module fpu_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_in_valid,
   output logic                 o_in_ready,
   input  logic [EXP_W+MAN_W:0] i_a,
   input  logic [EXP_W+MAN_W:0] i_b,
   input  logic                 i_sub,
   input  logic [TAG_W-1:0]     i_in_tag,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [EXP_W+MAN_W:0] o_z,
   output logic [TAG_W-1:0]     o_out_tag,
   output logic [3:0]           o_flags
);
   localparam int W = 1 + EXP_W + MAN_W;
   localparam int F = MAN_W + 4;
   localparam int X = EXP_W + 2;
   localparam logic [EXP_W-1:0]    EXP_ONES  = '1;
   localparam logic [W-1:0]        QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [X-1:0]        ALIGN_MAX = X'(F - 1);
   localparam logic signed [X-1:0] EXP_INF   = {2'b00, EXP_ONES};
   localparam logic signed [X-1:0] EXP_ZERO  = '0;

   function automatic logic [X-1:0] lzc(input logic [F-1:0] v);
      logic [X-1:0] n;
      logic         done;
      n    = '0;
      done = 1'b0;
      for (int i = F - 1; i >= 0; i--) begin
         if (!done) begin
            if (v[i]) done = 1'b1;
            else      n = n + X'(1);
         end
      end
      return n;
   endfunction

   logic w_adv;
   assign w_adv      = ~o_out_valid | i_out_ready;
   assign o_in_ready = w_adv;

   // ---------------- stage 1: capture (SUB folded into B's sign) ----------------
   logic             r_s1_valid;
   logic [W-1:0]     r_s1_a, r_s1_b;
   logic [TAG_W-1:0] r_s1_tag;

   // NOTE: pipeline state uses non-blocking assignments so each stage samples its predecessor's pre-edge value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_tag   <= '0;
      end else if (w_adv) begin
         r_s1_valid <= i_in_valid;
         r_s1_a     <= i_a;
         r_s1_b     <= {i_b[W-1] ^ i_sub, i_b[W-2:0]};
         r_s1_tag   <= i_in_tag;
      end
   end

   // ---------------- stage 2: classify, order by magnitude, align ----------------
   logic             w_sa, w_sb, w_za, w_zb, w_inf_a, w_inf_b, w_nan_a, w_nan_b, w_a_big;
   logic [EXP_W-1:0] w_ea, w_eb, w_exp_big;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic [F-1:0]     w_sig_a, w_sig_b, w_sig_big, w_sig_sm, w_shifted, w_aligned;
   logic [X-1:0]     w_diff;
   logic             w_sign_big, w_lost, w_spec;
   logic [W-1:0]     w_spec_z;
   logic [3:0]       w_spec_f;

   assign {w_sa, w_ea, w_fa} = r_s1_a;
   assign {w_sb, w_eb, w_fb} = r_s1_b;
   assign w_za    = (w_ea == '0);
   assign w_zb    = (w_eb == '0);
   assign w_inf_a = (w_ea == EXP_ONES) && (w_fa == '0);
   assign w_inf_b = (w_eb == EXP_ONES) && (w_fb == '0);
   assign w_nan_a = (w_ea == EXP_ONES) && (w_fa != '0);
   assign w_nan_b = (w_eb == EXP_ONES) && (w_fb != '0);
   assign w_sig_a = w_za ? '0 : {1'b1, w_fa, 3'b000};
   assign w_sig_b = w_zb ? '0 : {1'b1, w_fb, 3'b000};
   assign w_a_big = {w_ea, w_fa} >= {w_eb, w_fb};
   assign w_spec  = w_nan_a | w_nan_b | w_inf_a | w_inf_b;

   always_comb begin
      w_sign_big = w_sb;
      w_exp_big  = w_eb;
      w_sig_big  = w_sig_b;
      w_sig_sm   = w_sig_a;
      w_diff     = {2'b00, w_eb} - {2'b00, w_ea};
      if (w_a_big) begin
         w_sign_big = w_sa;
         w_exp_big  = w_ea;
         w_sig_big  = w_sig_a;
         w_sig_sm   = w_sig_b;
         w_diff     = {2'b00, w_ea} - {2'b00, w_eb};
      end
      w_shifted = w_sig_sm >> w_diff;
      w_lost    = |(w_sig_sm & ~({F{1'b1}} << w_diff));
      if (w_diff >= ALIGN_MAX) w_aligned = {{(F-1){1'b0}}, |w_sig_sm};
      else                     w_aligned = {w_shifted[F-1:1], w_shifted[0] | w_lost};

      w_spec_z = {w_sb, EXP_ONES, {MAN_W{1'b0}}};
      w_spec_f = 4'b0000;
      if (w_nan_a || w_nan_b) begin
         w_spec_z = QNAN;
      end else if (w_inf_a && w_inf_b && (w_sa != w_sb)) begin
         w_spec_z = QNAN;
         w_spec_f = 4'b1000;
      end else if (w_inf_a) begin
         w_spec_z = {w_sa, EXP_ONES, {MAN_W{1'b0}}};
      end
   end

   logic             r_s2_valid, r_s2_sign, r_s2_eff_sub, r_s2_zsign, r_s2_spec;
   logic [TAG_W-1:0] r_s2_tag;
   logic [EXP_W-1:0] r_s2_exp;
   logic [F-1:0]     r_s2_big, r_s2_sm;
   logic [W-1:0]     r_s2_spec_z;
   logic [3:0]       r_s2_spec_f;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s2_valid <= 1'b0; r_s2_sign <= 1'b0; r_s2_eff_sub <= 1'b0; r_s2_zsign <= 1'b0;
         r_s2_spec <= 1'b0; r_s2_tag <= '0; r_s2_exp <= '0; r_s2_big <= '0; r_s2_sm <= '0;
         r_s2_spec_z <= '0; r_s2_spec_f <= '0;
      end else if (w_adv) begin
         r_s2_valid   <= r_s1_valid;
         r_s2_tag     <= r_s1_tag;
         r_s2_sign    <= w_sign_big;
         r_s2_eff_sub <= w_sa ^ w_sb;
         r_s2_zsign   <= w_sa & w_sb;
         r_s2_exp     <= w_exp_big;
         r_s2_big     <= w_sig_big;
         r_s2_sm      <= w_aligned;
         r_s2_spec    <= w_spec;
         r_s2_spec_z  <= w_spec_z;
         r_s2_spec_f  <= w_spec_f;
      end
   end

   // ---------------- stage 3: magnitude add/subtract (big >= small, never negative) ----------------
   logic [F:0]              w_sum;
   logic                    r_s3_valid, r_s3_sign, r_s3_zsign, r_s3_spec;
   logic [TAG_W-1:0]        r_s3_tag;
   logic signed [X-1:0]     r_s3_exp;
   logic [F:0]              r_s3_sum;
   logic [W-1:0]            r_s3_spec_z;
   logic [3:0]              r_s3_spec_f;

   assign w_sum = r_s2_eff_sub ? ({1'b0, r_s2_big} - {1'b0, r_s2_sm})
                               : ({1'b0, r_s2_big} + {1'b0, r_s2_sm});

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s3_valid <= 1'b0; r_s3_sign <= 1'b0; r_s3_zsign <= 1'b0; r_s3_spec <= 1'b0;
         r_s3_tag <= '0; r_s3_exp <= '0; r_s3_sum <= '0; r_s3_spec_z <= '0; r_s3_spec_f <= '0;
      end else if (w_adv) begin
         r_s3_valid  <= r_s2_valid;
         r_s3_tag    <= r_s2_tag;
         r_s3_sign   <= r_s2_sign;
         r_s3_zsign  <= r_s2_zsign;
         r_s3_exp    <= {2'b00, r_s2_exp};
         r_s3_sum    <= w_sum;
         r_s3_spec   <= r_s2_spec;
         r_s3_spec_z <= r_s2_spec_z;
         r_s3_spec_f <= r_s2_spec_f;
      end
   end

   // ---------------- stage 4: normalize ----------------
   logic [X-1:0]        w_lz;
   logic [F-1:0]        w_norm;
   logic signed [X-1:0] w_norm_exp;

   assign w_lz = lzc(r_s3_sum[F-1:0]);

   always_comb begin
      if (r_s3_sum[F]) begin
         w_norm     = {r_s3_sum[F:2], r_s3_sum[1] | r_s3_sum[0]};
         w_norm_exp = r_s3_exp + X'(1);
      end else begin
         w_norm     = r_s3_sum[F-1:0] << w_lz;
         w_norm_exp = r_s3_exp - w_lz;
      end
   end

   logic                r_s4_valid, r_s4_sign, r_s4_zsign, r_s4_zero, r_s4_spec;
   logic [TAG_W-1:0]    r_s4_tag;
   logic signed [X-1:0] r_s4_exp;
   logic [F-1:0]        r_s4_norm;
   logic [W-1:0]        r_s4_spec_z;
   logic [3:0]          r_s4_spec_f;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s4_valid <= 1'b0; r_s4_sign <= 1'b0; r_s4_zsign <= 1'b0; r_s4_zero <= 1'b0;
         r_s4_spec <= 1'b0; r_s4_tag <= '0; r_s4_exp <= '0; r_s4_norm <= '0;
         r_s4_spec_z <= '0; r_s4_spec_f <= '0;
      end else if (w_adv) begin
         r_s4_valid  <= r_s3_valid;
         r_s4_tag    <= r_s3_tag;
         r_s4_sign   <= r_s3_sign;
         r_s4_zsign  <= r_s3_zsign;
         r_s4_zero   <= (r_s3_sum == '0);
         r_s4_exp    <= w_norm_exp;
         r_s4_norm   <= w_norm;
         r_s4_spec   <= r_s3_spec;
         r_s4_spec_z <= r_s3_spec_z;
         r_s4_spec_f <= r_s3_spec_f;
      end
   end

   // ---------------- stage 5: round to nearest even, range check, pack ----------------
   logic                w_inc, w_nx;
   logic [MAN_W+1:0]    w_mant;
   logic signed [X-1:0] w_exp_r;
   logic [MAN_W-1:0]    w_frac;
   logic [W-1:0]        w_z;
   logic [3:0]          w_flags;

   assign w_inc   = r_s4_norm[2] & (r_s4_norm[1] | r_s4_norm[0] | r_s4_norm[3]);
   assign w_nx    = |r_s4_norm[2:0];
   assign w_mant  = {1'b0, r_s4_norm[F-1:3]} + (MAN_W+2)'(w_inc);
   assign w_exp_r = r_s4_exp + {{(X-1){1'b0}}, w_mant[MAN_W+1]};
   assign w_frac  = w_mant[MAN_W+1] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];

   always_comb begin
      w_z     = {r_s4_sign, w_exp_r[EXP_W-1:0], w_frac};
      w_flags = {3'b000, w_nx};
      if (r_s4_spec) begin
         w_z     = r_s4_spec_z;
         w_flags = r_s4_spec_f;
      end else if (r_s4_zero) begin
         w_z     = {r_s4_zsign, {(W-1){1'b0}}};
         w_flags = 4'b0000;
      end else if (w_exp_r >= EXP_INF) begin
         w_z     = {r_s4_sign, EXP_ONES, {MAN_W{1'b0}}};
         w_flags = 4'b0101;
      end else if (w_exp_r <= EXP_ZERO) begin
         w_z     = {r_s4_sign, {(W-1){1'b0}}};
         w_flags = 4'b0011;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_out_valid <= 1'b0;
         o_z         <= '0;
         o_out_tag   <= '0;
         o_flags     <= '0;
      end else if (w_adv) begin
         o_out_valid <= r_s4_valid;
         o_z         <= w_z;
         o_out_tag   <= r_s4_tag;
         o_flags     <= w_flags;
      end
   end
endmodule

// File: doc/fpu_addsub_pipe.md
FPU_ADDSUB_PIPE -- requirements
Module: fpu_addsub_pipe

Parameters
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 The block SHALL have parameter MAN_W, default 23, stored fraction width; operand width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have parameter TAG_W, default 4, width of the opaque tag carried alongside each operation.

Interface
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RESET  in  1  asynchronous, active-low reset.
REQ-006 IN_VALID  in  1  operands and mode valid this cycle.
REQ-007 IN_READY  out  1  block accepts an operation when IN_VALID and IN_READY are both high.
REQ-008 A, B  in  W  IEEE-style operands.
REQ-009 SUB  in  1  0 computes A+B; 1 computes A-B.
REQ-010 IN_TAG  in  TAG_W  tag returned with the result.
REQ-011 OUT_VALID  out  1  Z, OUT_TAG and flags valid.
REQ-012 OUT_READY  in  1  consumer takes the result when OUT_VALID and OUT_READY are both high.
REQ-013 Z  out  W  result.
REQ-014 OUT_TAG  out  TAG_W  tag of the operation that produced Z.
REQ-015 FLAGS  out  4  {NV invalid, OF overflow, UF underflow-flush, NX inexact}.

Function
REQ-016 Pipeline SHALL have 5 register stages: capture, align, add, normalize, round/pack; latency = 5 cycles from accept to OUT_VALID with OUT_READY held high.
REQ-017 Global advance = ~OUT_VALID | OUT_READY; IN_READY SHALL equal advance; with advance low, all stages and valid bits SHALL hold.
REQ-018 Each stage SHALL carry a valid bit; bubbles propagate and are not compacted; throughput is 1 operation/cycle with no stall.
REQ-019 SUB SHALL be applied by inverting B's sign at capture.
REQ-020 Inputs with exponent 0 SHALL be treated as signed zero (denormals flushed); other finite inputs use hidden bit 1.
REQ-021 Align: the smaller-exponent significand SHALL be right-shifted by the exponent difference into a field with 3 extra low bits (guard, round, sticky); shifted-out ones OR into sticky; shifts >= MAN_W+3 SHALL leave only sticky.
REQ-022 Add: signed magnitude add/subtract of aligned significands, result sign from the larger magnitude.
REQ-023 Normalize: carry-out shifts right 1 (exponent+1, sticky kept); otherwise left by leading-zero count (exponent minus count).
REQ-024 Round: round-to-nearest-even on guard/round/sticky; a rounding carry SHALL renormalize (exponent+1).
REQ-025 Exact cancellation SHALL give +0; (+0)+(+0)=+0, (-0)+(-0)=-0.
REQ-026 Biased exponent >= 2^EXP_W-1 after rounding SHALL give signed infinity, OF=1, NX=1.
REQ-027 Biased exponent <= 0 with nonzero significand SHALL give signed zero, UF=1, NX=1.
REQ-028 Any NaN input, or infinities of opposite effective sign, SHALL give quiet NaN (sign 0, exponent all ones, fraction MSB 1, rest 0); NV=1 only for the infinity case.
REQ-029 Infinity plus finite SHALL return that infinity, no flags.
REQ-030 NX SHALL be 1 whenever any of guard/round/sticky was nonzero before rounding.

Reset
REQ-031 While RESET is low, all valid bits, Z, OUT_TAG and FLAGS SHALL be 0 asynchronously; IN_READY SHALL be 1 after reset since OUT_VALID=0.
REQ-032 Operations in flight at reset assertion SHALL be discarded; no result for them SHALL appear after release.

Verification
REQ-033 A=0x3F800000, B=0x40000000, SUB=0 -> Z=0x40400000, FLAGS=0, exactly 5 cycles after accept.
REQ-034 A=0x3F800000, B=0x3F800000, SUB=1 -> Z=0x00000000, FLAGS=0; A=0x7F7FFFFF+B=0x7F7FFFFF -> Z=0x7F800000, OF=1, NX=1.
REQ-035 A=0x3F800000, B=0x33800000 (2^-24) -> Z=0x3F800000, NX=1 (tie to even); B=0x33800001 -> Z=0x3F800001, NX=1.
REQ-036 A=0x7F800000, B=0xFF800000, SUB=0 -> Z=0x7FC00000, NV=1; A=0x7F800000+B=0x3F800000 -> Z=0x7F800000, FLAGS=0.
REQ-037 Issue 8 back-to-back ops with tags 0..7, OUT_READY low for 4 cycles mid-stream -> IN_READY low while stalled, all 8 results returned in order, tags intact, none duplicated.
REQ-038 Assert RESET with 3 ops in flight -> outputs 0 immediately; after release with no new input, OUT_VALID stays 0 for 10 cycles.
